// File: rtl/hex_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_arbiter
// Purpose  : Owns the eight 7-segment digit registers HEX0..HEX7 and shares
//            them between two valid/ready write requesters. Each requester
//            writes either a raw active-low segment pattern or a 4-bit hex
//            value that is decoded here. A clear command blanks all digits
//            with an 8-cycle sweep.
// Options  : BLINK_EN - adds blink_mask[7:0] and a BLINK_DIV-cycle prescaler.
//            While the blink phase is high, masked digits show BLANK_PATTERN.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_arbiter #(
  parameter logic [7:0] BLANK_PATTERN = 8'hFF,
  parameter int         PRIO_FIXED    = 0,
  parameter int         BLINK_DIV     = 12_500_000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  // Requester 0
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_digit,
  input  logic       req0_hex,
  input  logic [7:0] req0_data,
  // Requester 1
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_digit,
  input  logic       req1_hex,
  input  logic [7:0] req1_data,
  // Clear control
  input  logic       clear_req,
`ifdef BLINK_EN
  input  logic [7:0] blink_mask,
`endif
  output logic       busy,
  // Active-low segment drives, bit 7 = dp
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5,
  output logic [7:0] HEX6,
  output logic [7:0] HEX7
);

  localparam logic PRIO_FIXED_B = (PRIO_FIXED != 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic       busy_q;
  // 1 = requester 1 won the most recent transfer, so requester 0 is next.
  logic       last_grant_q;
  logic [7:0] digit_q [8];

  logic       grant0;
  logic       grant1;
  logic       wr_en;
  logic [2:0] wr_digit;
  logic [7:0] wr_pattern;
  logic [7:0] disp [8];

  // Hex value to active-low segments; dp bit is lit when d[4] is set.
  function automatic logic [7:0] hex_decode(input logic [4:0] d);
    logic [6:0] seg;
    case (d[3:0])
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return {~d[4], seg};
  endfunction

  // Arbitration: clear beats writes, then fixed or round-robin priority.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == ST_IDLE) && !clear_req) begin
      grant0 = req0_valid & (~req1_valid | PRIO_FIXED_B | last_grant_q);
      grant1 = req1_valid & ~grant0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Select the winning requester's target digit and pattern.
  always_comb begin
    wr_en      = 1'b0;
    wr_digit   = req0_digit;
    wr_pattern = req0_data;
    if (grant0) begin
      wr_en      = 1'b1;
      wr_digit   = req0_digit;
      wr_pattern = req0_hex ? hex_decode(req0_data[4:0]) : req0_data;
    end else if (grant1) begin
      wr_en      = 1'b1;
      wr_digit   = req1_digit;
      wr_pattern = req1_hex ? hex_decode(req1_data[4:0]) : req1_data;
    end
  end

  // Control FSM: owns digit registers, sweep counter, busy and grant history.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        digit_q[i] <= BLANK_PATTERN;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
          end else if (wr_en) begin
            digit_q[wr_digit] <= wr_pattern;
            last_grant_q      <= grant1;
          end
        end
        ST_CLEAR: begin
          // clear_req is deliberately ignored here: a sweep never restarts.
          digit_q[cnt_q] <= BLANK_PATTERN;
          cnt_q          <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BLINK_EN
  localparam int                   PRESC_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(BLINK_DIV - 1);

  logic [PRESC_W-1:0] presc_q;
  logic               phase_q;

  // Free-running prescaler; the blink phase flips once every BLINK_DIV cycles.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      presc_q <= '0;
      phase_q <= 1'b0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Masked digits are overridden on the output only; storage is untouched.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      disp[i] = (phase_q && blink_mask[i]) ? BLANK_PATTERN : digit_q[i];
    end
  end
`else
  // Without blinking the pins follow the digit registers directly.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      disp[i] = digit_q[i];
    end
  end

  // BLINK_DIV only sizes the blink prescaler; nothing is built from it here.
  if (BLINK_DIV < 1) begin : g_no_blink_div
  end
`endif

  assign busy = busy_q;
  assign HEX0 = disp[0];
  assign HEX1 = disp[1];
  assign HEX2 = disp[2];
  assign HEX3 = disp[3];
  assign HEX4 = disp[4];
  assign HEX5 = disp[5];
  assign HEX6 = disp[6];
  assign HEX7 = disp[7];

endmodule
`default_nettype wire
